// File: rtl/memory_port.sv
// Single-port RAM front end: clears every word to INIT_VAL after reset, then serves one read or write per cycle.
// Optional macro MEMORY_PORT_OUTREG_EN adds an output register stage (response latency 2 instead of 1).
module memory_port #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH_LOG2 = 12,
  parameter int                    WP_BASE    = 2**DEPTH_LOG2,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_done,
  output logic                  err,
  output logic                  dbg_state
);

  // Handshake: a request is taken on every rising edge with req && ready; nothing is queued
  // while ready is low. Each taken request yields exactly one rd_valid or wr_done pulse, in order.
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0] WP_LIM = (ADDR_WIDTH + 1)'(WP_BASE);

  state_t                  state, state_nx;
  logic [DEPTH_LOG2-1:0]   clr_cnt, clr_cnt_nx;
  logic                    acc, in_range, wp_hit;
  logic                    ram_we, ram_re;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_q;
  logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];
  logic                    s1_rd, s1_wr, s1_err;
  logic [DATA_WIDTH-1:0]   s1_data;

  assign in_range  = (addr >> DEPTH_LOG2) == '0;
  assign wp_hit    = {1'b0, addr} >= WP_LIM;
  assign dbg_state = (state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    ready      = 1'b0;
    acc        = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = addr[DEPTH_LOG2-1:0];
    ram_wdata  = wr_data;
    case (state)
      CLEAR: begin
        ram_we     = 1'b1;
        ram_addr   = clr_cnt;
        ram_wdata  = INIT_VAL;
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_nx = RUN;
      end
      RUN: begin
        ready = 1'b1;
        acc   = req;
        // Out-of-range and protected accesses never touch the RAM port
        if (acc && in_range) begin
          if (we) ram_we = !wp_hit;
          else    ram_re = 1'b1;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_rd  <= 1'b0;
      s1_wr  <= 1'b0;
      s1_err <= 1'b0;
    end else begin
      s1_rd  <= acc && !we;
      s1_wr  <= acc && we;
      s1_err <= acc && (!in_range || (we && wp_hit));
    end
  end

  assign s1_data = s1_err ? '0 : ram_q;

`ifdef MEMORY_PORT_OUTREG_EN
  logic                  rd_valid_q, wr_done_q, err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= s1_rd;
      wr_done_q  <= s1_wr;
      err_q      <= s1_err;
      if (s1_rd) rd_data_q <= s1_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign wr_done  = wr_done_q;
  assign err      = err_q;
  assign rd_data  = rd_data_q;
`else
  logic [DATA_WIDTH-1:0] rd_hold;

  // ram_q is not reset, so the held copy supplies rd_data between read pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rd_hold <= '0;
    else if (s1_rd) rd_hold <= s1_data;
  end

  assign rd_valid = s1_rd;
  assign wr_done  = s1_wr;
  assign err      = s1_err;
  assign rd_data  = s1_rd ? s1_data : rd_hold;
`endif

endmodule

// File: tb/tb_memory_port.sv
// Directed bench for memory_port (DEPTH_LOG2=4, WP_BASE=12, INIT_VAL=0x3C); latency follows MEMORY_PORT_OUTREG_EN.
module tb_memory_port;

  localparam int         DW   = 8;
  localparam int         AW   = 16;
  localparam logic [7:0] INIT = 8'h3C;
`ifdef MEMORY_PORT_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic          clk = 1'b0, resetn = 1'b0, req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ready, rd_valid, wr_done, err, dbg_state;
  logic [DW-1:0] rd_data;

  int checks = 0, errors = 0, cyc = 0, last_k = 0;
  logic       log_rv  [1024];
  logic       log_wd  [1024];
  logic       log_err [1024];
  logic       log_rdy [1024];
  logic [7:0] log_rd  [1024];

  memory_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(4), .WP_BASE(12), .INIT_VAL(INIT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
    .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data), .wr_done(wr_done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // outputs are logged on the falling edge, indexed by the number of rising edges so far
  always @(negedge clk) begin
    if (cyc < 1024) begin
      log_rv[cyc]  = rd_valid;
      log_wd[cyc]  = wr_done;
      log_err[cyc] = err;
      log_rdy[cyc] = ready;
      log_rd[cyc]  = rd_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  // driver tasks
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wr_data = d;
    last_k = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0; we = 1'b0;
    end
  endtask

  task automatic release_and_count(output int n, output int pulses);
    @(negedge clk);
    resetn = 1'b1;
    n = 0; pulses = 0;
    while (ready !== 1'b1 && n < 40) begin
      n++;
      if (rd_valid !== 1'b0 || wr_done !== 1'b0 || err !== 1'b0) pulses++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n, p, k0;
    resetn = 1'b0;
    idle(3);
    checks++;
    if ({ready, rd_valid, wr_done, err, dbg_state} !== 5'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b rv=%b wd=%b err=%b st=%b rd=%h want all 0",
               ready, rd_valid, wr_done, err, dbg_state, rd_data);
    end
    release_and_count(n, p);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL clear_window got %0d cycles want 16", n); end
    checks++;
    if (p !== 0) begin errors++; $display("FAIL clear_pulses got %0d want 0", p); end
    checks++;
    if (dbg_state !== 1'b1) begin errors++; $display("FAIL run_state got %b want 1", dbg_state); end
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, AW'(i), 8'h00);
      if (i == 0) k0 = last_k;
    end
    idle(L + 3);
    checks++;
    if (log_rv[k0+L-1] !== 1'b0) begin errors++; $display("FAIL init_early_rv got %b want 0", log_rv[k0+L-1]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (log_rv[k0+L+i] !== 1'b1 || log_err[k0+L+i] !== 1'b0 || log_rd[k0+L+i] !== INIT) begin
        errors++;
        $display("FAIL init_read[%0d] got rv=%b err=%b rd=%h want rv=1 err=0 rd=%h",
                 i, log_rv[k0+L+i], log_err[k0+L+i], log_rd[k0+L+i], INIT);
      end
    end
  endtask

  task automatic test_write_read;
    int k;
    issue(1'b1, 16'h0003, 8'hA5);
    k = last_k;
    issue(1'b0, 16'h0003, 8'h00);
    idle(L + 3);
    checks++;
    if (log_wd[k+L-1] !== 1'b0) begin errors++; $display("FAIL wr_early got wd=%b want 0", log_wd[k+L-1]); end
    checks++;
    if (log_wd[k+L] !== 1'b1 || log_err[k+L] !== 1'b0 || log_rv[k+L] !== 1'b0) begin
      errors++;
      $display("FAIL wr_done got wd=%b err=%b rv=%b want 1 0 0", log_wd[k+L], log_err[k+L], log_rv[k+L]);
    end
    checks++;
    if (log_rv[k+L+1] !== 1'b1 || log_rd[k+L+1] !== 8'hA5 || log_err[k+L+1] !== 1'b0 || log_wd[k+L+1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_wr got rv=%b rd=%h err=%b wd=%b want 1 a5 0 0",
               log_rv[k+L+1], log_rd[k+L+1], log_err[k+L+1], log_wd[k+L+1]);
    end
    checks++;
    if (log_rv[k+L+2] !== 1'b0 || log_rd[k+L+2] !== 8'hA5) begin
      errors++;
      $display("FAIL rd_hold got rv=%b rd=%h want 0 a5", log_rv[k+L+2], log_rd[k+L+2]);
    end
  endtask

  task automatic test_out_of_range;
    int k;
    issue(1'b0, 16'h0010, 8'h00);
    k = last_k;
    issue(1'b1, 16'h0010, 8'hEE);
    issue(1'b0, 16'h0000, 8'h00);
    idle(L + 3);
    checks++;
    if (log_rv[k+L] !== 1'b1 || log_err[k+L] !== 1'b1 || log_rd[k+L] !== 8'h00) begin
      errors++;
      $display("FAIL oor_read got rv=%b err=%b rd=%h want 1 1 00", log_rv[k+L], log_err[k+L], log_rd[k+L]);
    end
    checks++;
    if (log_wd[k+L+1] !== 1'b1 || log_err[k+L+1] !== 1'b1 || log_rv[k+L+1] !== 1'b0) begin
      errors++;
      $display("FAIL oor_write got wd=%b err=%b rv=%b want 1 1 0", log_wd[k+L+1], log_err[k+L+1], log_rv[k+L+1]);
    end
    checks++;
    if (log_rv[k+L+2] !== 1'b1 || log_err[k+L+2] !== 1'b0 || log_rd[k+L+2] !== INIT) begin
      errors++;
      $display("FAIL oor_alias got rv=%b err=%b rd=%h want 1 0 %h", log_rv[k+L+2], log_err[k+L+2], log_rd[k+L+2], INIT);
    end
  endtask

  task automatic test_protect;
    int k;
    logic       exp_pulse [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_isrd  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_err   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_rd    [6] = '{8'h00, INIT, 8'h00, 8'h77, 8'h00, INIT};
    issue(1'b1, 16'h000C, 8'h5A);
    k = last_k;
    issue(1'b0, 16'h000C, 8'h00);
    issue(1'b1, 16'h000B, 8'h77);
    issue(1'b0, 16'h000B, 8'h00);
    issue(1'b1, 16'h000F, 8'h66);
    issue(1'b0, 16'h000F, 8'h00);
    idle(L + 3);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ((exp_isrd[i] ? log_rv[k+L+i] : log_wd[k+L+i]) !== exp_pulse[i] || log_err[k+L+i] !== exp_err[i] ||
          (exp_isrd[i] && log_rd[k+L+i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL protect[%0d] got rv=%b wd=%b err=%b rd=%h want err=%b rd=%h",
                 i, log_rv[k+L+i], log_wd[k+L+i], log_err[k+L+i], log_rd[k+L+i], exp_err[i], exp_rd[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic [7:0] exp_q [$];
    exp_q = {8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, AW'(i), exp_q[i]);
      if (i == 0) k = last_k;
    end
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), 8'h00);
    idle(L + 3);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_rdy[k+i] !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, log_rdy[k+i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_wd[k+L+i] !== 1'b1 || log_rv[k+L+i] !== 1'b0 || log_err[k+L+i] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_wr[%0d] got wd=%b rv=%b err=%b want 1 0 0", i, log_wd[k+L+i], log_rv[k+L+i], log_err[k+L+i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_rv[k+L+3+i] !== 1'b1 || log_wd[k+L+3+i] !== 1'b0 || log_rd[k+L+3+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_rd[%0d] got rv=%b wd=%b rd=%h want 1 0 %h",
                 i, log_rv[k+L+3+i], log_wd[k+L+3+i], log_rd[k+L+3+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n, p, k;
    // reset while a read is in flight
    issue(1'b0, 16'h000B, 8'h00);
    @(negedge clk);
    req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({ready, rd_valid, wr_done, err, dbg_state} !== 5'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL run_reset got rdy=%b rv=%b wd=%b err=%b st=%b rd=%h want all 0",
               ready, rd_valid, wr_done, err, dbg_state, rd_data);
    end
    // release, let the clear run part way, offer an ignored write, then reset again
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0005; wr_data = 8'h99;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_clear_ready got %b want 0", ready); end
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    checks++;
    if (wr_done !== 1'b0) begin errors++; $display("FAIL ignored_req got wd=%b want 0", wr_done); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({ready, rd_valid, wr_done, err, dbg_state} !== 5'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL clear_reset got rdy=%b rv=%b wd=%b err=%b st=%b rd=%h want all 0",
               ready, rd_valid, wr_done, err, dbg_state, rd_data);
    end
    release_and_count(n, p);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL reclear_window got %0d cycles want 16", n); end
    checks++;
    if (p !== 0) begin errors++; $display("FAIL reclear_pulses got %0d want 0", p); end
    issue(1'b0, 16'h0005, 8'h00);
    k = last_k;
    issue(1'b0, 16'h000B, 8'h00);
    issue(1'b0, 16'h0003, 8'h00);
    idle(L + 3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_rv[k+L+i] !== 1'b1 || log_err[k+L+i] !== 1'b0 || log_rd[k+L+i] !== INIT) begin
        errors++;
        $display("FAIL reclear_read[%0d] got rv=%b err=%b rd=%h want 1 0 %h",
                 i, log_rv[k+L+i], log_err[k+L+i], log_rd[k+L+i], INIT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_out_of_range;
    test_protect;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
